// File: rtl/cache_line_xfer_ctrl.sv
// cache_line_xfer_ctrl: cache miss engine. Optionally writes a dirty victim line
// back to memory as a burst of 32-bit beats, then gathers a refill burst into a
// line buffer and commits it to the data array in a single write cycle.
module cache_line_xfer_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int SET_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic                     op_wb,
  input  logic [SET_W-1:0]         op_set,
  input  logic [31:0]              op_wb_addr,
  input  logic [31:0]              op_fill_addr,
  output logic                     op_done,
  output logic                     proto_err,
  output logic                     mem_rd_req_valid,
  input  logic                     mem_rd_req_ready,
  output logic [31:0]              mem_rd_addr,
  input  logic [31:0]              mem_rd_data,
  input  logic                     mem_rd_valid,
  output logic                     mem_rd_ready,
  input  logic                     mem_rd_last,
  output logic                     mem_wr_req_valid,
  input  logic                     mem_wr_req_ready,
  output logic [31:0]              mem_wr_addr,
  output logic [31:0]              mem_wr_data,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic                     mem_wr_last,
  output logic [SET_W-1:0]         da_raddr,
  input  logic [LINE_WORDS*32-1:0] da_rdata,
  output logic [SET_W-1:0]         da_waddr,
  output logic                     da_wen,
  output logic [LINE_WORDS*32-1:0] da_wdata
);

  localparam int LINE_W = LINE_WORDS * 32;
  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WB_LOAD  = 3'd1,
    S_WB_REQ   = 3'd2,
    S_WB_DATA  = 3'd3,
    S_RF_REQ   = 3'd4,
    S_RF_DATA  = 3'd5,
    S_RF_WRITE = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SET_W-1:0]   r_set;
  logic [31:0]        r_wb_addr;
  logic [31:0]        r_fill_addr;
  logic [LINE_W-1:0]  r_buf;
  logic               r_op_ready;
  logic               r_op_done;
  logic               r_proto_err;
  logic               r_rd_req_valid;
  logic               r_rd_ready;
  logic               r_wr_req_valid;
  logic               r_wr_valid;
  logic               r_wr_last;
  logic [31:0]        r_wr_data;
  logic               r_wen;

  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cnt_last;

  // Select one 32-bit beat out of a full line.
  function automatic logic [31:0] f_word(input logic [LINE_W-1:0] line,
                                         input logic [CNT_W-1:0]  idx);
    return line[{idx, 5'd0} +: 32];
  endfunction

  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_cnt_last = (r_cnt == LAST_BEAT);

  assign op_ready         = r_op_ready;
  assign op_done          = r_op_done;
  assign proto_err        = r_proto_err;
  assign mem_rd_req_valid = r_rd_req_valid;
  assign mem_rd_addr      = r_fill_addr;
  assign mem_rd_ready     = r_rd_ready;
  assign mem_wr_req_valid = r_wr_req_valid;
  assign mem_wr_addr      = r_wb_addr;
  assign mem_wr_data      = r_wr_data;
  assign mem_wr_valid     = r_wr_valid;
  assign mem_wr_last      = r_wr_last;
  assign da_raddr         = r_set;
  assign da_waddr         = r_set;
  assign da_wen           = r_wen;
  assign da_wdata         = r_buf;

  // Transfer sequencer: every output is set on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_set          <= '0;
      r_wb_addr      <= '0;
      r_fill_addr    <= '0;
      r_buf          <= '0;
      r_op_ready     <= 1'b0;
      r_op_done      <= 1'b0;
      r_proto_err    <= 1'b0;
      r_rd_req_valid <= 1'b0;
      r_rd_ready     <= 1'b0;
      r_wr_req_valid <= 1'b0;
      r_wr_valid     <= 1'b0;
      r_wr_last      <= 1'b0;
      r_wr_data      <= '0;
      r_wen          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_op_ready && op_valid) begin
            r_set       <= op_set;
            r_wb_addr   <= op_wb_addr;
            r_fill_addr <= op_fill_addr;
            r_cnt       <= '0;
            r_op_ready  <= 1'b0;
            if (op_wb) begin
              r_state <= S_WB_LOAD;
            end else begin
              r_state        <= S_RF_REQ;
              r_rd_req_valid <= 1'b1;
            end
          end else begin
            // Ready comes up one cycle after reset release or after DONE.
            r_op_ready <= 1'b1;
          end
        end
        S_WB_LOAD: begin
          r_buf          <= da_rdata;
          r_wr_req_valid <= 1'b1;
          r_state        <= S_WB_REQ;
        end
        S_WB_REQ: begin
          if (mem_wr_req_ready) begin
            r_wr_req_valid <= 1'b0;
            r_cnt          <= '0;
            r_wr_valid     <= 1'b1;
            r_wr_data      <= f_word(r_buf, '0);
            r_wr_last      <= (LAST_BEAT == '0);
            r_state        <= S_WB_DATA;
          end
        end
        S_WB_DATA: begin
          if (mem_wr_ready) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_last) begin
              r_wr_valid     <= 1'b0;
              r_wr_last      <= 1'b0;
              r_rd_req_valid <= 1'b1;
              r_state        <= S_RF_REQ;
            end else begin
              r_wr_data <= f_word(r_buf, w_cnt_nxt);
              r_wr_last <= (w_cnt_nxt == LAST_BEAT);
            end
          end
        end
        S_RF_REQ: begin
          if (mem_rd_req_ready) begin
            r_rd_req_valid <= 1'b0;
            r_rd_ready     <= 1'b1;
            r_state        <= S_RF_DATA;
          end
        end
        S_RF_DATA: begin
          if (mem_rd_valid) begin
            r_buf[{r_cnt, 5'd0} +: 32] <= mem_rd_data;
            r_cnt                      <= w_cnt_nxt;
            // A misplaced or missing last marker is flagged but the count rules.
            if (mem_rd_last != w_cnt_last) begin
              r_proto_err <= 1'b1;
            end
            if (w_cnt_last) begin
              r_rd_ready <= 1'b0;
              r_wen      <= 1'b1;
              r_state    <= S_RF_WRITE;
            end
          end
        end
        S_RF_WRITE: begin
          r_wen     <= 1'b0;
          r_op_done <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_op_done  <= 1'b0;
          r_op_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_xfer_ctrl.sv
// tb_cache_line_xfer_ctrl: directed + randomized bench for the cache miss engine.
// The bench plays memory and data array, and predicts each transfer from the
// line contents, the beat list and the stall plan.
module tb_cache_line_xfer_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid, op_ready, op_wb, op_done, proto_err;
  logic [2:0]   op_set;
  logic [31:0]  op_wb_addr, op_fill_addr;
  logic         mem_rd_req_valid, mem_rd_req_ready;
  logic [31:0]  mem_rd_addr, mem_rd_data;
  logic         mem_rd_valid, mem_rd_ready, mem_rd_last;
  logic         mem_wr_req_valid, mem_wr_req_ready;
  logic [31:0]  mem_wr_addr, mem_wr_data;
  logic         mem_wr_valid, mem_wr_ready, mem_wr_last;
  logic [2:0]   da_raddr, da_waddr;
  logic [255:0] da_rdata, da_wdata;
  logic         da_wen;

  logic [255:0] tb_arr  [8];
  logic [255:0] ref_arr [8];
  logic [31:0]  beat_q  [8];

  int  n_cmp = 0;
  int  n_err = 0;
  int  gcyc  = 0;
  int  last_done_g = 0;
  bit  exp_proto = 1'b0;
  logic [255:0] last_wdata;

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  assign da_rdata = tb_arr[da_raddr];

  cache_line_xfer_ctrl #(.LINE_WORDS(8), .SET_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_wb(op_wb), .op_set(op_set),
    .op_wb_addr(op_wb_addr), .op_fill_addr(op_fill_addr),
    .op_done(op_done), .proto_err(proto_err),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_last(mem_rd_last),
    .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_ready(mem_wr_req_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_last(mem_wr_last),
    .da_raddr(da_raddr), .da_rdata(da_rdata), .da_waddr(da_waddr),
    .da_wen(da_wen), .da_wdata(da_wdata)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic mem_idle();
    mem_rd_req_ready = 1'b0; mem_wr_req_ready = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = '0;
    mem_wr_ready = 1'b0;
  endtask

  // One whole transfer: request, emulate memory, observe, then compare with prediction.
  task automatic xfer(input bit wb, input logic [2:0] set, input logic [31:0] wba,
                      input logic [31:0] fa, input bit stall, input int lastpos,
                      input bit hold, input int abort_beat, input bit b2b);
    int cyc, wr_i, rd_i, wr_st, rd_st, wen_n, wen_cyc, done_c, wrq_c, rdq_c, unstable, exp_done;
    bit accepted, prev_stall;
    logic [31:0]  prev_wd, got_wra, got_rda;
    logic [2:0]   got_waddr;
    logic [255:0] exp_line, got_wdata;
    logic [31:0]  wr_seen[$];
    bit           wr_last_seen[$];
    cyc = 0; wr_i = 0; rd_i = 0; wr_st = 0; rd_st = 0; wen_n = 0; wen_cyc = -1;
    done_c = -1; wrq_c = -1; rdq_c = -1; unstable = 0; prev_stall = 1'b0;
    prev_wd = '0; got_wra = '0; got_rda = '0; got_waddr = '0; got_wdata = '0;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = beat_q[i];

    @(posedge clk); #1;
    op_valid = 1'b1; op_wb = wb; op_set = set; op_wb_addr = wba; op_fill_addr = fa;
    accepted = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (op_valid && op_ready) begin accepted = 1'b1; break; end
    end
    check("accept", accepted, 1);
    if (!accepted) begin op_valid = 1'b0; return; end
    if (b2b) check("b2b_accept_cycle", gcyc, last_done_g + 1);

    while (cyc < 300 && done_c < 0) begin
      @(posedge clk); #1;
      if (!hold) op_valid = 1'b0;
      mem_wr_req_ready = 1'b1;
      mem_rd_req_ready = 1'b1;
      mem_wr_ready = !(stall && (wr_i == 2 || wr_i == 6) && wr_st < 3);
      mem_rd_valid = (rd_i < 8) && !(stall && (rd_i == 2 || rd_i == 6) && rd_st < 3);
      mem_rd_data  = beat_q[rd_i & 7];
      mem_rd_last  = (rd_i == lastpos);
      @(negedge clk);
      cyc++;
      if (abort_beat >= 0 && mem_rd_ready && rd_i == abort_beat) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl_zero", {op_ready, op_done, proto_err, mem_rd_req_valid, mem_rd_ready,
                                  mem_wr_req_valid, mem_wr_valid, mem_wr_last, da_wen}, 0);
        check("abort_buf_zero", da_wdata, 0);
        check("abort_addr_zero", {mem_rd_addr, mem_wr_addr, mem_wr_data}, 0);
        check("abort_no_wen", wen_n, 0);
        @(negedge clk);
        mem_idle();
        op_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
      if (prev_stall && !(mem_wr_valid && mem_wr_data === prev_wd)) unstable++;
      prev_stall = mem_wr_valid && !mem_wr_ready;
      prev_wd    = mem_wr_data;
      if (mem_wr_valid && mem_wr_ready) begin
        wr_seen.push_back(mem_wr_data);
        wr_last_seen.push_back(mem_wr_last);
        wr_i++; wr_st = 0;
      end else if (mem_wr_valid) begin
        wr_st++;
      end
      if (mem_rd_ready && mem_rd_valid) begin
        rd_i++; rd_st = 0;
      end else if (mem_rd_ready) begin
        rd_st++;
      end
      if (mem_wr_req_valid && mem_wr_req_ready) begin wrq_c = cyc; got_wra = mem_wr_addr; end
      if (mem_rd_req_valid && mem_rd_req_ready) begin rdq_c = cyc; got_rda = mem_rd_addr; end
      if (da_wen) begin
        wen_n++; wen_cyc = cyc; got_waddr = da_waddr; got_wdata = da_wdata;
        tb_arr[da_waddr] = da_wdata;
      end
      if (op_done) begin done_c = cyc; last_done_g = gcyc; end
    end
    op_valid = hold;
    check("done_seen", done_c >= 0, 1);
    if (done_c < 0) return;

    exp_done = 11 + (wb ? 10 : 0) + (stall ? (wb ? 12 : 6) : 0);
    if (lastpos != 7) exp_proto = 1'b1;
    check("done_cycle", done_c, exp_done);
    check("wen_count", wen_n, 1);
    check("wen_cycle", wen_cyc, exp_done - 1);
    check("waddr", got_waddr, set);
    check("wdata", got_wdata, exp_line);
    check("rd_addr", got_rda, fa);
    check("wr_stable", unstable, 0);
    check("proto_err", proto_err, exp_proto);
    if (wb) begin
      check("wr_addr", got_wra, wba);
      check("wr_before_rd", wrq_c < rdq_c, 1);
      check("wr_beats", wr_seen.size(), 8);
      if (wr_seen.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          check($sformatf("wb_data%0d", i), wr_seen[i], ref_arr[set][32*i +: 32]);
          check($sformatf("wb_last%0d", i), wr_last_seen[i], (i == 7));
        end
      end
    end else begin
      check("no_wr_beats", wr_seen.size(), 0);
    end
    last_wdata   = got_wdata;
    ref_arr[set] = exp_line;
  endtask

  task automatic rand_beats();
    for (int i = 0; i < 8; i++) beat_q[i] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_wb = 1'b0; op_set = '0;
    op_wb_addr = '0; op_fill_addr = '0;
    mem_idle();
    for (int s = 0; s < 8; s++) begin
      ref_arr[s] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tb_arr[s]  = ref_arr[s];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl_zero", {op_ready, op_done, proto_err, mem_rd_req_valid, mem_rd_ready,
                            mem_wr_req_valid, mem_wr_valid, mem_wr_last, da_wen}, 0);
    check("rst_buf_zero", da_wdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready_after", op_ready, 1);

    // Refill only, known beats
    for (int i = 0; i < 8; i++) beat_q[i] = 32'h11111111 * (i + 1);
    xfer(1'b0, 3'd5, 32'h0, 32'h0000_1000, 1'b0, 7, 1'b0, -1, 1'b0);
    check("t1_word0", last_wdata[31:0], 32'h11111111);
    check("t1_word7", last_wdata[255:224], 32'h88888888);

    // Writeback + refill with known victim line
    for (int k = 0; k < 8; k++) begin
      ref_arr[2][32*k +: 32] = 32'hA0 + k;
      tb_arr[2][32*k +: 32]  = 32'hA0 + k;
    end
    rand_beats();
    xfer(1'b1, 3'd2, 32'h0000_2000, 32'h0000_3000, 1'b0, 7, 1'b0, -1, 1'b0);

    // Stalls on beats 2 and 6 in both directions
    rand_beats();
    xfer(1'b1, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFE0,
         $urandom & 32'hFFFF_FFE0, 1'b1, 7, 1'b0, -1, 1'b0);

    // Misplaced last marker, then a clean transfer with the flag still set
    rand_beats();
    xfer(1'b0, 3'd6, 32'h0, 32'h0000_4000, 1'b0, 4, 1'b0, -1, 1'b0);
    rand_beats();
    xfer(1'b1, 3'd6, 32'h0000_5000, 32'h0000_6000, 1'b0, 7, 1'b0, -1, 1'b0);

    // Reset during refill beat 3 aborts the transfer and clears the flag
    rand_beats();
    xfer(1'b0, 3'd1, 32'h0, 32'h0000_7000, 1'b0, 7, 1'b0, 3, 1'b0);
    exp_proto = 1'b0;
    @(negedge clk); @(negedge clk);
    check("abort_ready_after", op_ready, 1);
    check("abort_proto_clear", proto_err, 0);
    check("abort_array_untouched", tb_arr[1], ref_arr[1]);
    rand_beats();
    xfer(1'b1, 3'd1, 32'h0000_8000, 32'h0000_9000, 1'b0, 7, 1'b0, -1, 1'b0);

    // op_valid held high across a transfer: next accept right after DONE
    rand_beats();
    xfer(1'b0, 3'd3, 32'h0, 32'h0000_A000, 1'b0, 7, 1'b1, -1, 1'b0);
    rand_beats();
    xfer(1'b1, 3'd4, 32'h0000_B000, 32'h0000_C000, 1'b0, 7, 1'b0, -1, 1'b1);

    // Randomized mix
    for (int n = 0; n < 8; n++) begin
      rand_beats();
      xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFE0,
           $urandom & 32'hFFFF_FFE0, 1'($urandom_range(0, 1)), 7, 1'b0, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
